// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master. One transaction per accepted start:
// START, {dev_addr, rw}, ACK, one data byte (write or read), ACK/NACK, STOP.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   start               one-cycle request, honoured only in IDLE
//   rw                  0 = write wdata, 1 = read one byte
//   dev_addr[6:0]       target address
//   wdata[7:0]          byte to write
//   sda_in              bus SDA level, synchronous to clk
//   scl                 SCL output (idle 1)
//   sda_out             SDA drive, 1 = release, 0 = pull low (idle 1)
//   busy                cycle after accept through the done cycle
//   done                one-cycle completion pulse
//   ack_err             NACK seen on address or write data (valid from done)
//   rdata[7:0]          byte read on the last successful read
module i2c_master #(
    parameter int unsigned CLK_DIV = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] wdata,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    localparam int unsigned Q  = CLK_DIV / 4;
    localparam int unsigned QW = (Q > 1) ? $clog2(Q) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_RD_NACK,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      abyte_q, abyte_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      shift_q, shift_d;
    logic            nack_q, nack_d;
    logic            scl_q, scl_d;
    logic            sda_q, sda_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic [7:0]      rdata_q, rdata_d;

    logic            q_last;
    logic [1:0]      last_phase;
    logic            sample;
    logic            slot_end;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd7;
            abyte_q   <= 8'h00;
            wdata_q   <= 8'h00;
            shift_q   <= 8'h00;
            nack_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            abyte_q   <= abyte_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next state, counters, and next-cycle bus levels
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        abyte_d   = abyte_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        scl_d     = 1'b1;
        sda_d     = 1'b1;

        q_last = (qcnt_q == QW'(Q - 1));
        case (state_q)
            S_START: last_phase = 2'd1;
            S_STOP:  last_phase = 2'd2;
            default: last_phase = 2'd3;
        endcase
        // SCL-high midpoint: last cycle of phase C
        sample   = q_last && (phase_q == 2'd2);
        slot_end = q_last && (phase_q == last_phase);

        if (state_q == S_IDLE) begin
            qcnt_d  = '0;
            phase_d = 2'd0;
            // done_q blocks a start arriving in the done cycle
            if (start && !done_q) begin
                state_d   = S_START;
                abyte_d   = {dev_addr, rw};
                wdata_d   = wdata;
                nack_d    = 1'b0;
                ack_err_d = 1'b0;
                bit_d     = 3'd7;
            end
        end else begin
            qcnt_d = q_last ? '0 : qcnt_q + QW'(1);
            if (q_last) begin
                phase_d = phase_q + 2'd1;
            end
            if (sample) begin
                case (state_q)
                    S_ADDR_ACK, S_WR_ACK: if (sda_in) nack_d = 1'b1;
                    S_RD:                 shift_d = {shift_q[6:0], sda_in};
                    default:              ;
                endcase
            end
            if (slot_end) begin
                phase_d = 2'd0;
                case (state_q)
                    S_START: begin
                        state_d = S_ADDR;
                        bit_d   = 3'd7;
                    end
                    S_ADDR: begin
                        if (bit_q == 3'd0) state_d = S_ADDR_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    S_ADDR_ACK: begin
                        bit_d = 3'd7;
                        if (nack_q)          state_d = S_STOP;
                        else if (abyte_q[0]) state_d = S_RD;
                        else                 state_d = S_WR;
                    end
                    S_WR: begin
                        if (bit_q == 3'd0) state_d = S_WR_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    S_WR_ACK: state_d = S_STOP;
                    S_RD: begin
                        if (bit_q == 3'd0) state_d = S_RD_NACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    S_RD_NACK: state_d = S_STOP;
                    S_STOP: begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        ack_err_d = nack_q;
                        if (abyte_q[0] && !nack_q) rdata_d = shift_q;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Bus levels depend only on the slot, so SDA is stable across a bit
        case (state_d)
            S_IDLE: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
            S_START: begin
                scl_d = 1'b1;
                sda_d = 1'b0;
            end
            S_ADDR: begin
                scl_d = phase_d[1];
                sda_d = abyte_q[bit_d];
            end
            S_WR: begin
                scl_d = phase_d[1];
                sda_d = wdata_q[bit_d];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD, S_RD_NACK: begin
                scl_d = phase_d[1];
                sda_d = 1'b1;
            end
            S_STOP: begin
                scl_d = (phase_d != 2'd0);
                sda_d = (phase_d == 2'd2);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE) || done_d;
    end

    assign scl     = scl_q;
    assign sda_out = sda_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed transactions against a bus-level slave model;
// expectations are queued per transaction and checked by a monitor on done.
module tb_i2c_master;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned Q       = CLK_DIV / 4;
    localparam int          LEN_FULL = 77 * Q;
    localparam int          LEN_NACK = 41 * Q;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       sda_in;
    logic       scl;
    logic       sda_out;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    // slave model configuration and state
    logic [6:0] slv_addr = 7'h51;
    logic       slv_ack_data = 1'b1;
    logic [7:0] slv_rbyte = 8'h00;
    logic       slv_drv = 1'b1;
    logic       addr_ok = 1'b0;
    logic       rd_flag = 1'b0;
    logic [31:0] cap = '0;
    int         rises = 0;
    int         hichg = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    int         cyc = 0;
    int         acc_cyc = 0;
    logic       busy_prev = 1'b0;
    int         n_done = 0;
    logic       end_req = 1'b0;

    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic       ack_err;
        logic [7:0] rdata;
        int         len;
        logic [7:0] abyte;
        logic [7:0] dbyte;
        logic       chk_d;
        int         rises;
    } exp_t;
    exp_t expq[$];

    assign sda_in = sda_out & slv_drv;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .wdata    (wdata),
        .sda_in   (sda_in),
        .scl      (scl),
        .sda_out  (sda_out),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] getb(int first);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = cap[first+i];
        return b;
    endfunction

    // Slave model: watches SCL/SDA edges, drives ACKs and read data on SCL fall
    initial forever begin
        logic [7:0] ab;
        @(negedge clk);
        if (scl && prev_scl && (sda_out != prev_sda)) begin
            if (!sda_out) begin
                rises   = 0;
                cap     = '0;
                hichg   = 1;
                slv_drv = 1'b1;
                addr_ok = 1'b0;
            end else begin
                hichg++;
            end
        end
        if (scl && !prev_scl) begin
            rises++;
            if (rises < 32) cap[rises] = sda_out;
        end else if (!scl && prev_scl) begin
            if (rises == 8) begin
                ab      = getb(1);
                addr_ok = (ab[7:1] == slv_addr);
                rd_flag = ab[0];
                slv_drv = !addr_ok;
            end else if (rises >= 9 && rises <= 16) begin
                slv_drv = (addr_ok && rd_flag) ? slv_rbyte[3'(16 - rises)] : 1'b1;
            end else if (rises == 17) begin
                slv_drv = (addr_ok && !rd_flag && slv_ack_data) ? 1'b0 : 1'b1;
            end else begin
                slv_drv = 1'b1;
            end
        end
        prev_scl = scl;
        prev_sda = sda_out;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: reset values while rst_n is low, scoreboard compare on done
    initial forever begin
        @(negedge clk or negedge rst_n or posedge end_req);
        if (end_req) begin
            chk("queue_drained", expq.size(), 0);
            chk("done_count", n_done, 7);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (!rst_n) begin
            #1;
            chk("rst_scl", int'(scl), 1);
            chk("rst_sda", int'(sda_out), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_ack_err", int'(ack_err), 0);
            chk("rst_rdata", int'(rdata), 0);
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) acc_cyc = cyc;
            busy_prev = busy;
            if (done) begin
                n_done++;
                chk("pending_txn", int'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("ack_err", int'(ack_err), int'(e.ack_err));
                    chk("rdata", int'(rdata), int'(e.rdata));
                    chk("length", cyc - acc_cyc, e.len);
                    chk("addr_byte", int'(getb(1)), int'(e.abyte));
                    if (e.chk_d) chk("data_byte", int'(getb(10)), int'(e.dbyte));
                    chk("scl_rises", rises, e.rises);
                    chk("sda_hi_changes", hichg, 2);
                    chk("addr_ack_released", int'(cap[9]), 1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy || done) begin
            n++;
            if (n > 2000) begin
                $display("FAIL wait_idle: busy still high after %0d cycles", n);
                $fatal(1);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done) begin
            n++;
            if (n > 2000) begin
                $display("FAIL wait_done: no done after %0d cycles", n);
                $fatal(1);
            end
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic ackd, input logic [7:0] rb, input exp_t e);
        wait_idle();
        slv_ack_data = ackd;
        slv_rbyte    = rb;
        dev_addr     = a;
        rw           = r;
        wdata        = wd;
        start        = 1'b1;
        expq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // write 0x3C to 0x51, ACKed
        issue(7'h51, 1'b0, 8'h3C, 1'b1, 8'h00, '{1'b0, 8'h00, LEN_FULL, 8'hA2, 8'h3C, 1'b1, 19});
        wait_done();
        // read 0xCA from 0x51 (master sda_out stays released during data)
        issue(7'h51, 1'b1, 8'h00, 1'b1, 8'hCA, '{1'b0, 8'hCA, LEN_FULL, 8'hA3, 8'hFF, 1'b1, 19});
        wait_done();
        // address NACK on 0x22: short transaction, rdata kept
        issue(7'h22, 1'b0, 8'h5A, 1'b1, 8'h00, '{1'b1, 8'hCA, LEN_NACK, 8'h44, 8'h00, 1'b0, 10});
        wait_done();
        // write-data NACK: full length, ack_err set
        issue(7'h51, 1'b0, 8'h96, 1'b0, 8'h00, '{1'b1, 8'hCA, LEN_FULL, 8'hA2, 8'h96, 1'b1, 19});
        wait_done();

        // read with an ignored start while busy
        issue(7'h51, 1'b1, 8'h00, 1'b1, 8'h35, '{1'b0, 8'h35, LEN_FULL, 8'hA3, 8'hFF, 1'b1, 19});
        repeat (30) @(negedge clk);
        dev_addr = 7'h22;
        rw       = 1'b0;
        wdata    = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        // start on the done cycle (ignored) and held one more cycle (accepted)
        dev_addr     = 7'h51;
        rw           = 1'b0;
        wdata        = 8'hE7;
        slv_ack_data = 1'b1;
        start        = 1'b1;
        expq.push_back('{1'b0, 8'h35, LEN_FULL, 8'hA2, 8'hE7, 1'b1, 19});
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset in the middle of WR, then a fresh write
        wait_idle();
        dev_addr = 7'h51;
        rw       = 1'b0;
        wdata    = 8'hAA;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(7'h51, 1'b0, 8'h11, 1'b1, 8'h00, '{1'b0, 8'h00, LEN_FULL, 8'hA2, 8'h11, 1'b1, 19});
        wait_done();

        repeat (4) @(negedge clk);
        end_req = 1'b1;
    end

endmodule
